mem_init_engine: RTL and testbench

- Parametrised successor to the RC4 S-array initialiser.
- Sequentially writes a programmable address range of an on-chip single-port RAM, one word per clock, using a selectable data pattern: identity, constant fill or offset ramp.
- Supports restart after completion, range wrap-around and an optional read-back verify pass.
- Sits between the top-level control FSM and the RAM's address, data and wren mux.

---
 rtl/mem_init_pkg.sv | 36 +++
 rtl/mem_init_engine_if.sv | 42 ++++
 rtl/mem_init_addr_ctr.sv | 37 +++
 rtl/mem_init_engine.sv | 176 +++++++++++++++++
 tb/tb_mem_init_engine.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/mem_init_pkg.sv
// Shared types and the data-pattern generator for the memory init engine.
// Optional read-back verify is enabled by defining MEM_INIT_VERIFY_EN.
package mem_init_pkg;

  typedef enum logic [1:0] {
    IDENTITY = 2'b00,
    FILL     = 2'b01,
    RAMP     = 2'b10,
    RSVD     = 2'b11
  } mode_t;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    RD_ISSUE,
    RD_WAIT,
    RD_CHECK,
    DONE
  } state_t;

  localparam int unsigned PAT_W = 32;

  // Computed at full width; callers keep the low DATA_W bits, which gives the
  // required truncation / modulo-2^DATA_W behaviour for every mode.
  function automatic logic [PAT_W-1:0] pattern(input mode_t            mode,
                                               input logic [PAT_W-1:0] counter,
                                               input logic [PAT_W-1:0] offset,
                                               input logic [PAT_W-1:0] fill_value);
    case (mode)
      FILL:    pattern = fill_value;
      RAMP:    pattern = fill_value + offset;
      default: pattern = counter;
    endcase
  endfunction

endpackage

// File: rtl/mem_init_engine_if.sv
// Control and RAM-side bus of the memory init engine.
// Read data q and the error outputs exist only when MEM_INIT_VERIFY_EN is defined.
interface mem_init_engine_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              start;
  logic [1:0]        mode;
  logic [ADDR_W-1:0] start_addr;
  logic [ADDR_W-1:0] end_addr;
  logic [DATA_W-1:0] fill_value;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] data;
  logic              wren;
  logic              busy;
  logic              done;
`ifdef MEM_INIT_VERIFY_EN
  logic [DATA_W-1:0] q;
  logic              error;
  logic [ADDR_W-1:0] error_addr;

  modport master (
    output start, mode, start_addr, end_addr, fill_value, q,
    input  address, data, wren, busy, done, error, error_addr
  );

  modport slave (
    input  start, mode, start_addr, end_addr, fill_value, q,
    output address, data, wren, busy, done, error, error_addr
  );
`else
  modport master (
    output start, mode, start_addr, end_addr, fill_value,
    input  address, data, wren, busy, done
  );

  modport slave (
    input  start, mode, start_addr, end_addr, fill_value,
    output address, data, wren, busy, done
  );
`endif
endinterface

// File: rtl/mem_init_addr_ctr.sv
// Loadable wrapping address counter with a run-relative offset counter
// and a combinational terminal-address flag.
module mem_init_addr_ctr #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_i,
  input  logic              inc_i,
  input  logic [ADDR_W-1:0] load_val_i,
  input  logic [ADDR_W-1:0] end_val_i,
  output logic [ADDR_W-1:0] cnt_o,
  output logic [ADDR_W-1:0] offset_o,
  output logic              last_o
);

  logic [ADDR_W-1:0] cnt_q;
  logic [ADDR_W-1:0] off_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
      off_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
      off_q <= '0;
    end else if (inc_i) begin
      cnt_q <= cnt_q + ADDR_W'(1);
      off_q <= off_q + ADDR_W'(1);
    end
  end

  assign cnt_o    = cnt_q;
  assign offset_o = off_q;
  assign last_o   = (cnt_q == end_val_i);

endmodule

// File: rtl/mem_init_engine.sv
// Sequential RAM range initialiser: identity, constant fill or offset ramp.
// Define MEM_INIT_VERIFY_EN to add the read-back verify pass.
//
// state    | meaning
// IDLE     | after reset, waiting for start
// WRITE    | one RAM write per cycle over the latched range
// RD_ISSUE | verify: present read address
// RD_WAIT  | verify: wait out the remaining RAM read latency
// RD_CHECK | verify: compare q against the regenerated pattern
// DONE     | run complete, start restarts
module mem_init_engine
  import mem_init_pkg::*;
#(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 8,
  parameter int READ_LAT = 1
) (
  input logic              clk,
  input logic              reset,
  mem_init_engine_if.slave bus
);

  state_t            state_q;
  mode_t             mode_q;
  logic [ADDR_W-1:0] start_q;
  logic [ADDR_W-1:0] end_q;
  logic [DATA_W-1:0] fill_q;
  logic              wren_q;
  logic              busy_q;
  logic              done_q;

  logic              accept_start;
  logic              ctr_load;
  logic              ctr_inc;
  logic [ADDR_W-1:0] ctr_load_val;
  logic [ADDR_W-1:0] cnt;
  logic [ADDR_W-1:0] off;
  logic              last;
  logic [PAT_W-1:0]  pat32;
  logic [DATA_W-1:0] pat_w;
  logic              unused_pat_bits;

`ifdef MEM_INIT_VERIFY_EN
  localparam int WAIT_W = (READ_LAT > 2) ? $clog2(READ_LAT - 1) : 1;

  logic              error_q;
  logic [ADDR_W-1:0] error_addr_q;
  logic [WAIT_W-1:0] wait_q;
`else
  localparam int unused_read_lat = READ_LAT;
`endif

  assign accept_start = bus.start && (state_q == IDLE || state_q == DONE);
  assign ctr_load_val = accept_start ? bus.start_addr : start_q;

  always_comb begin
    ctr_load = accept_start;
    ctr_inc  = 1'b0;
    case (state_q)
      WRITE: begin
        ctr_inc = !last;
`ifdef MEM_INIT_VERIFY_EN
        ctr_load = last;  // rewind to start_addr for the read-back pass
`endif
      end
`ifdef MEM_INIT_VERIFY_EN
      RD_CHECK: ctr_inc = !last;
`endif
      default: ;
    endcase
  end

  mem_init_addr_ctr #(.ADDR_W(ADDR_W)) u_ctr (
    .clk       (clk),
    .reset     (reset),
    .load_i    (ctr_load),
    .inc_i     (ctr_inc),
    .load_val_i(ctr_load_val),
    .end_val_i (end_q),
    .cnt_o     (cnt),
    .offset_o  (off),
    .last_o    (last)
  );

  assign pat32           = pattern(mode_q, PAT_W'(cnt), PAT_W'(off), PAT_W'(fill_q));
  assign pat_w           = pat32[DATA_W-1:0];
  assign unused_pat_bits = ^pat32;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      mode_q       <= IDENTITY;
      start_q      <= '0;
      end_q        <= '0;
      fill_q       <= '0;
      wren_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
`ifdef MEM_INIT_VERIFY_EN
      error_q      <= 1'b0;
      error_addr_q <= '0;
      wait_q       <= '0;
`endif
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (bus.start) begin
            state_q      <= WRITE;
            mode_q       <= mode_t'(bus.mode);
            start_q      <= bus.start_addr;
            end_q        <= bus.end_addr;
            fill_q       <= bus.fill_value;
            wren_q       <= 1'b1;
            busy_q       <= 1'b1;
            done_q       <= 1'b0;
`ifdef MEM_INIT_VERIFY_EN
            error_q      <= 1'b0;
            error_addr_q <= '0;
`endif
          end
        end
        WRITE: begin
          if (last) begin
            wren_q <= 1'b0;
`ifdef MEM_INIT_VERIFY_EN
            state_q <= RD_ISSUE;
`else
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
`endif
          end
        end
`ifdef MEM_INIT_VERIFY_EN
        RD_ISSUE: begin
          if (READ_LAT > 1) begin
            wait_q  <= WAIT_W'((READ_LAT > 1) ? READ_LAT - 2 : 0);
            state_q <= RD_WAIT;
          end else begin
            state_q <= RD_CHECK;
          end
        end
        RD_WAIT: begin
          if (wait_q == '0) state_q <= RD_CHECK;
          else              wait_q  <= wait_q - WAIT_W'(1);
        end
        RD_CHECK: begin
          if (bus.q != pat_w) begin
            error_q <= 1'b1;
            if (!error_q) error_addr_q <= cnt;
          end
          if (last) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            state_q <= RD_ISSUE;
          end
        end
`endif
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.address = (state_q == IDLE || state_q == DONE) ? '0 : cnt;
  assign bus.data    = (state_q == WRITE) ? pat_w : '0;
  assign bus.wren    = wren_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
`ifdef MEM_INIT_VERIFY_EN
  assign bus.error      = error_q;
  assign bus.error_addr = error_addr_q;
`endif

endmodule

// File: tb/tb_mem_init_engine.sv
// Self-checking bench for mem_init_engine: directed plus randomized runs
// scored against an arithmetic model of the expected write sequence.
module tb_mem_init_engine;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;
`ifdef MEM_INIT_VERIFY_EN
  localparam int READ_LAT = 2;
`else
  localparam int READ_LAT = 1;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  mem_init_engine_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_init_engine #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .READ_LAT(READ_LAT)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_assert = 0;
  int n_fail   = 0;

  logic [7:0] wr_addr_q[$];
  logic [7:0] wr_data_q[$];
  int         done_lat;
  int         busy_bad;
  logic       done_at_start;

`ifdef MEM_INIT_VERIFY_EN
  logic [7:0] mem[256];
  logic [7:0] q_pipe[READ_LAT];
  int         corrupt_addr = -1;

  always @(posedge clk) begin
    if (bus.wren)
      mem[bus.address] <= (int'(bus.address) == corrupt_addr) ? (bus.data ^ 8'h5A) : bus.data;
    q_pipe[0] <= mem[bus.address];
    for (int i = 1; i < READ_LAT; i++) q_pipe[i] <= q_pipe[i-1];
  end
  assign bus.q = q_pipe[READ_LAT-1];
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [1:0] m, input logic [7:0] s, input logic [7:0] e,
                        input logic [7:0] f, input bit poke);
    wr_addr_q.delete();
    wr_data_q.delete();
    bus.mode       = m;
    bus.start_addr = s;
    bus.end_addr   = e;
    bus.fill_value = f;
    bus.start      = 1'b1;
    tick();
    done_at_start  = bus.done;
    bus.start      = 1'b0;
    bus.mode       = 2'($urandom);
    bus.start_addr = 8'($urandom);
    bus.end_addr   = 8'($urandom);
    bus.fill_value = 8'($urandom);
    done_lat = 0;
    busy_bad = 0;
    while (!bus.done && done_lat < 5000) begin
      if (bus.wren) begin
        wr_addr_q.push_back(bus.address);
        wr_data_q.push_back(bus.data);
      end
      if (!bus.busy) busy_bad++;
      bus.start = poke ? 1'($urandom_range(0, 1)) : 1'b0;
      done_lat++;
      tick();
    end
    bus.start = 1'b0;
  endtask

  task automatic check_run(input string tag, input logic [1:0] m, input logic [7:0] s,
                           input logic [7:0] e, input logic [7:0] f);
    int n, bad, post_bad;
    logic [7:0] ea, ed;
    n = ((int'(e) - int'(s) + 256) % 256) + 1;
    chk({tag, "_done_clr"}, 32'(done_at_start), 0);
    chk({tag, "_nwr"}, wr_addr_q.size(), n);
    bad = 0;
    for (int k = 0; k < n && k < wr_addr_q.size(); k++) begin
      ea = 8'((int'(s) + k) % 256);
      case (m)
        2'b01:   ed = f;
        2'b10:   ed = 8'((int'(f) + k) % 256);
        default: ed = ea;
      endcase
      if (wr_addr_q[k] !== ea || wr_data_q[k] !== ed) bad++;
    end
    chk({tag, "_bad_words"}, bad, 0);
`ifdef MEM_INIT_VERIFY_EN
    chk({tag, "_done_lat"}, done_lat, n * (READ_LAT + 2));
`else
    chk({tag, "_done_lat"}, done_lat, n);
`endif
    chk({tag, "_busy"}, busy_bad, 0);
    post_bad = 0;
    repeat (3) begin
      tick();
      if (bus.wren !== 1'b0 || bus.done !== 1'b1 || bus.busy !== 1'b0) post_bad++;
    end
    chk({tag, "_post"}, post_bad, 0);
  endtask

  initial begin
    logic [1:0] rm;
    logic [7:0] rs, re, rf;
    bus.start = 1'b0;
    bus.mode = 2'b00;
    bus.start_addr = '0;
    bus.end_addr = '0;
    bus.fill_value = '0;

    repeat (3) tick();
    chk("rst_outputs", {bus.address, bus.data, bus.wren, bus.busy, bus.done}, 0);
    reset = 1'b1;
    repeat (2) tick();
    chk("idle_outputs", {bus.address, bus.data, bus.wren, bus.busy, bus.done}, 0);

    run_op(2'b00, 8'h00, 8'hFF, 8'h00, 1'b0);
    check_run("identity_full", 2'b00, 8'h00, 8'hFF, 8'h00);

    run_op(2'b01, 8'h10, 8'h13, 8'hA5, 1'b0);
    check_run("fill_a5", 2'b01, 8'h10, 8'h13, 8'hA5);

    run_op(2'b10, 8'hFD, 8'h01, 8'hFE, 1'b1);
    check_run("ramp_wrap", 2'b10, 8'hFD, 8'h01, 8'hFE);

    run_op(2'b00, 8'h42, 8'h42, 8'h00, 1'b1);
    check_run("single_a", 2'b00, 8'h42, 8'h42, 8'h00);
    run_op(2'b11, 8'h42, 8'h42, 8'h00, 1'b1);
    check_run("single_restart", 2'b11, 8'h42, 8'h42, 8'h00);

    // Abort a full run with reset while the 100th word is on the bus.
    bus.mode = 2'b00;
    bus.start_addr = 8'h00;
    bus.end_addr = 8'hFF;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (99) tick();
    chk("pre_rst_addr", {bus.wren, bus.address}, {1'b1, 8'd99});
    #2 reset = 1'b0;
    #1 chk("mid_rst_outputs", {bus.address, bus.data, bus.wren, bus.busy, bus.done}, 0);
    repeat (2) tick();
    chk("in_rst_outputs", {bus.address, bus.data, bus.wren, bus.busy, bus.done}, 0);
    reset = 1'b1;
    repeat (3) tick();
    chk("post_rst_idle", {bus.wren, bus.busy, bus.done}, 0);
    run_op(2'b10, 8'h80, 8'h20, 8'h33, 1'b0);
    check_run("after_rst", 2'b10, 8'h80, 8'h20, 8'h33);

    for (int r = 0; r < 6; r++) begin
      rm = 2'($urandom);
      rs = 8'($urandom);
      re = 8'($urandom);
      rf = 8'($urandom);
      run_op(rm, rs, re, rf, 1'($urandom_range(0, 1)));
      check_run("random", rm, rs, re, rf);
    end

`ifdef MEM_INIT_VERIFY_EN
    corrupt_addr = 8'h37;
    run_op(2'b00, 8'h30, 8'h3F, 8'h00, 1'b0);
    check_run("verify_bad", 2'b00, 8'h30, 8'h3F, 8'h00);
    chk("verify_bad_err", {bus.error, bus.error_addr}, {1'b1, 8'h37});
    corrupt_addr = -1;
    run_op(2'b10, 8'h30, 8'h3F, 8'h11, 1'b0);
    check_run("verify_clean", 2'b10, 8'h30, 8'h3F, 8'h11);
    chk("verify_clean_err", {bus.error, bus.error_addr}, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
